// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped UART transmitter (TX FIFO + serialiser) on a req/gnt/rvalid bus
//   Ports: clk_i, rst_i (async, active high);
//          bus in  req_i, we_i, addr_i[3:0], be_i[3:0], wdata_i[31:0];
//          bus out gnt_o (combinational), rvalid_o / rdata_o[31:0] (one cycle after each grant);
//          tx_o serial line (idle high); irq_o = CTRL.irq_en & FIFO empty & serialiser idle.
//   Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL.
//   Define UART_TX_PARITY_EN to add a parity bit after the data bits; CTRL[2] then selects odd parity.
module uart_tx_responder #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        tx_o,
   output logic        irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d, baud_q, baud_d, div_eff;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d, head;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
   logic [31:0] rdata_q, rdata_d, rd, lvl_w;
   logic [1:0]  reg_sel;
   logic tx_q, tx_d, irq_en_q, irq_en_d, rvalid_q;
   logic full, empty, busy, gnt, wr, push, pop, flush, avail, last, par_bit, odd_rd, unused;
`ifdef UART_TX_PARITY_EN
   localparam state_t AFTER_DATA = S_PARITY;
   logic odd_q, odd_d, par_q, par_d;
   assign par_bit = par_q ^ odd_q;
   assign odd_rd  = odd_q;
   always_comb begin
      odd_d = (wr && reg_sel == 2'd3 && be_i[0]) ? wdata_i[2] : odd_q;
      par_d = pop ? ^head : par_q;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         odd_q <= 1'b0;
         par_q <= 1'b0;
      end else begin
         odd_q <= odd_d;
         par_q <= par_d;
      end
`else
   localparam state_t AFTER_DATA = S_STOP;
   assign par_bit = 1'b1;
   assign odd_rd  = 1'b0;
`endif
   assign reg_sel  = addr_i[3:2];
   assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty    = wptr_q == rptr_q;
   assign busy     = state_q != S_IDLE;
   // stalls only on the registered full flag, so a same-cycle pop does not release the write
   assign gnt      = req_i & ~(we_i & (reg_sel == 2'd0) & full);
   assign wr       = gnt & we_i;
   assign push     = wr & (reg_sel == 2'd0) & be_i[0];
   assign flush    = wr & (reg_sel == 2'd3) & be_i[0] & wdata_i[1];
   // a flush also blocks the pop it would otherwise race with
   assign avail    = ~empty & ~flush;
   assign head     = mem_q[rptr_q[AW-1:0]];
   assign div_eff  = (baud_q == 16'd0) ? 16'd1 : baud_q;
   assign last     = cnt_q == 16'd0;
   assign level    = wptr_q - rptr_q;
   assign lvl_w    = 32'(level);
   assign rd       = reg_sel == 2'd1 ? {24'd0, (lvl_w > 32'd15) ? 4'd15 : lvl_w[3:0], 1'b0, busy, empty, full}
                   : reg_sel == 2'd2 ? {16'd0, baud_q}
                   : reg_sel == 2'd3 ? {29'd0, odd_rd, 1'b0, irq_en_q} : 32'd0;
   assign gnt_o    = gnt;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign tx_o     = tx_q;
   assign irq_o    = irq_en_q & empty & ~busy;
   assign unused   = ^{addr_i[1:0], be_i[3:2], wdata_i[31:16], lvl_w[31:4]};
   always_comb begin
      baud_d   = baud_q;
      irq_en_d = irq_en_q;
      if (wr && reg_sel == 2'd2 && be_i[0]) baud_d[7:0] = wdata_i[7:0];
      if (wr && reg_sel == 2'd2 && be_i[1]) baud_d[15:8] = wdata_i[15:8];
      if (wr && reg_sel == 2'd3 && be_i[0]) irq_en_d = wdata_i[0];
      rdata_d = (gnt & ~we_i) ? rd : 32'd0;
      wptr_d  = wptr_q + (AW+1)'(push);
      rptr_d  = flush ? wptr_q : rptr_q + (AW+1)'(pop);
   end
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE:   if (avail) begin pop = 1'b1; state_d = S_START; end
         S_START:  if (last) begin state_d = S_DATA; bit_d = 3'd0; end
         S_DATA:   if (last) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = AFTER_DATA;
         end
         S_PARITY: if (last) state_d = S_STOP;
         S_STOP:   if (last) begin pop = avail; state_d = avail ? S_START : S_IDLE; end
         default:  state_d = S_IDLE;
      endcase
      if (pop) shift_d = head;
      // reload on every bit so a new BAUDDIV applies from the next bit on
      cnt_d = (state_q == S_IDLE || last) ? div_eff - 16'd1 : cnt_q - 16'd1;
      // tx follows the next state so the registered line lines up with state_q
      tx_d  = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PARITY ? par_bit : 1'b1;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wptr_q   <= '0;
         rptr_q   <= '0;
         baud_q   <= DEFAULT_DIV;
         irq_en_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         baud_q   <= baud_d;
         irq_en_q <= irq_en_d;
         rvalid_q <= gnt;
         rdata_q  <= rdata_d;
      end
   always_ff @(posedge clk_i)
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i[7:0];
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: scoreboard bench for uart_tx_responder (bus responses and serial frames)
module tb_uart_tx_responder;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int NB = 10;
   localparam bit PAR = 1'b0;
`endif
   logic clk = 1'b0, rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0;
   logic [3:0] addr_i = '0, be_i = '0;
   logic [31:0] wdata_i = '0, rdata_o;
   logic gnt_o, rvalid_o, tx_o, irq_o;
   int checks = 0, errors = 0, stalls = 0, cyc = 0, cur_div = 434;
   logic [15:0] m_div = 16'd434;
   logic m_irq = 1'b0, m_odd = 1'b0, rx_busy = 1'b0, prev_gnt = 1'b0;
   logic [7:0]  exp_q[$];
   logic [31:0] rd_q[$];
   int start_q[$];

   uart_tx_responder dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .be_i(be_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .tx_o(tx_o), .irq_o(irq_o)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endtask

   task automatic chk1(input string n, input logic act, input logic exp);
      chk(n, {31'd0, act}, {31'd0, exp});
   endtask

   function automatic logic [31:0] ctrl_exp();
      return {29'd0, PAR & m_odd, 1'b0, m_irq};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // called just after a posedge; returns just after the edge that took the grant
   task automatic bus(input logic we, input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] exp, output bit ok);
      int t = 0;
      req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
      while (t < 2000) begin
         @(negedge clk);
         if (gnt_o) break;
         stalls++;
         t++;
      end
      ok = t < 2000;
      if (!ok) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         req_i = 1'b0;
      end else begin
         rd_q.push_back(exp);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      bit ok;
      bus(1'b0, {a[3:2], 2'($urandom)}, 4'($urandom), $urandom, exp, ok);
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
      bit ok;
      bus(1'b1, {a[3:2], 2'($urandom)}, be, wd, 32'd0, ok);
   endtask

   task automatic push(input logic [7:0] b, input logic [3:0] be);
      bit ok;
      bus(1'b1, {2'b00, 2'($urandom)}, be, {24'($urandom), b}, 32'd0, ok);
      if (ok && be[0]) exp_q.push_back(b);
   endtask

   task automatic set_div(input logic [15:0] v, input logic [3:0] be);
      wr(4'h8, be, {16'($urandom), v});
      if (be[0]) m_div[7:0] = v[7:0];
      if (be[1]) m_div[15:8] = v[15:8];
      cur_div = (m_div == 16'd0) ? 1 : int'(m_div);
   endtask

   task automatic wr_ctrl(input logic irq, input logic odd);
      wr(4'hC, 4'b0001, {24'($urandom), 5'($urandom), odd, 1'b0, irq});
      m_irq = irq;
      m_odd = odd;
   endtask

   task automatic wait_idle();
      int q = 0, t = 0;
      req_i = 1'b0;
      while (q < 4 && t < 20000) begin
         @(posedge clk);
         #1;
         t++;
         q = (exp_q.size() == 0 && !rx_busy && tx_o === 1'b1) ? q + 1 : 0;
      end
      if (q < 4) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // response monitor: one rvalid per grant, one cycle later, data from the scoreboard queue
   initial forever begin
      @(negedge clk);
      if (rst_i) begin
         prev_gnt = 1'b0;
         rd_q.delete();
      end else begin
         if (prev_gnt || rvalid_o) chk1("rvalid_after_gnt", rvalid_o, prev_gnt);
         if (rvalid_o) begin
            if (rd_q.size() == 0) chk("response_expected", 32'd0, 32'd1);
            else chk("rdata", rdata_o, rd_q.pop_front());
         end
         prev_gnt = gnt_o;
      end
   end

   // serial monitor: every cycle of each frame is compared with the ideal 8N1 (or 8P1) waveform
   initial forever begin
      @(negedge clk);
      if (!rst_i && tx_o === 1'b0) begin
         logic [7:0] b;
         logic [10:0] fb;
         int d, bad;
         bit aborted;
         rx_busy = 1'b1;
         d = cur_div;
         bad = 0;
         aborted = 1'b0;
         start_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("frame_expected", 32'd0, 32'd1);
            b = 8'h00;
         end else b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
         fb = {1'b1, ^b ^ m_odd, b, 1'b0};
`else
         fb = {2'b11, b, 1'b0};
`endif
         for (int i = 0; i < NB * d; i++) begin
            if (i > 0) @(negedge clk);
            if (rst_i) begin aborted = 1'b1; break; end
            if (tx_o !== fb[i / d]) bad++;
         end
         if (!aborted) chk($sformatf("frame_%02h_bad_cycles", b), bad, 32'd0);
         rx_busy = 1'b0;
      end
   end

   initial begin
      int n0, bad;
      logic [7:0] b;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_tx", tx_o, 1'b1);
      chk1("rst_irq", irq_o, 1'b0);
      chk1("rst_gnt", gnt_o, 1'b0);
      chk1("rst_rvalid", rvalid_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;
      tick(2);
      rd(4'h4, 32'h2);
      rd(4'h8, 32'd434);
      rd(4'hC, 32'd0);
      req_i = 1'b0;
      tick(2);
      // single frame at divisor 4
      set_div(16'd4, 4'b0011);
      push(8'h55, 4'b0001);
      wait_idle();
      rd(4'h4, 32'h2);
      rd(4'h8, 32'd4);
      // STATUS with two queued bytes and one in flight
      repeat (3) push(8'($urandom), 4'b0001);
      rd(4'h4, 32'h24);
      wait_idle();
      // back-to-back burst at divisor 1: stalls on full, frames with no gap
      set_div(16'd1, 4'b0011);
      wait_idle();
      stalls = 0;
      start_q.delete();
      repeat (12) push(8'($urandom), 4'b0001);
      wait_idle();
      chk1("burst_stalled", stalls > 0, 1'b1);
      chk("burst_frames", start_q.size(), 32'd12);
      bad = 0;
      for (int k = 1; k < start_q.size(); k++) if (start_q[k] - start_q[k-1] != NB) bad++;
      chk("burst_gaps", bad, 32'd0);
      // divisor 0 behaves as 1
      set_div(16'd0, 4'b0011);
      rd(4'h8, 32'd0);
      push(8'($urandom), 4'b0001);
      wait_idle();
      // interrupt
      set_div(16'd3, 4'b0011);
      wr_ctrl(1'b1, 1'b0);
      req_i = 1'b0;
      tick(2);
      chk1("irq_idle", irq_o, 1'b1);
      push(8'($urandom), 4'b0001);
      chk1("irq_after_push", irq_o, 1'b0);
      req_i = 1'b0;
      tick(15);
      chk1("irq_mid_frame", irq_o, 1'b0);
      wait_idle();
      chk1("irq_after_stop", irq_o, 1'b1);
      // flush mid-frame
      set_div(16'd4, 4'b0011);
      n0 = start_q.size();
      repeat (4) push(8'($urandom), 4'b0001);
      req_i = 1'b0;
      tick(12);
      wr(4'hC, 4'b0001, {29'd0, m_odd, 1'b1, m_irq});
      exp_q.delete();
      rd(4'h4, 32'h06);
      rd(4'hC, ctrl_exp());
      wait_idle();
      tick(100);
      chk("flush_one_frame", start_q.size() - n0, 32'd1);
      rd(4'h4, 32'h2);
      req_i = 1'b0;
      tick(1);
      chk1("irq_after_flush", irq_o, 1'b1);
      // randomized rounds
      for (int r = 0; r < 8; r++) begin
         set_div(16'(urandom_range_w(0, 5)), 4'(urandom_range_w(1, 3)));
         wr_ctrl(1'($urandom), 1'($urandom));
         for (int o = 0; o < int'(urandom_range_w(4, 12)); o++) begin
            case (urandom_range_w(0, 5))
               0, 1: push(8'($urandom), (urandom_range_w(0, 3) == 0) ? 4'b1110 : 4'b0001);
               2: rd(4'h8, {16'd0, m_div});
               3: rd(4'hC, ctrl_exp());
               4: rd(4'h0, 32'd0);
               default: wr(4'h4, 4'hF, $urandom);
            endcase
            if (urandom_range_w(0, 3) == 0) begin
               req_i = 1'b0;
               tick(int'(urandom_range_w(1, 4)));
            end
         end
         wait_idle();
      end
      // asynchronous reset in the middle of a frame
      wr_ctrl(1'b0, 1'b0);
      set_div(16'd4, 4'b0011);
      push(8'h00, 4'b0001);
      req_i = 1'b0;
      tick(10);
      chk1("tx_low_mid_frame", tx_o, 1'b0);
      #1;
      rst_i = 1'b1;
      #1;
      chk1("tx_async_reset", tx_o, 1'b1);
      exp_q.delete();
      m_div = 16'd434;
      cur_div = 434;
      m_irq = 1'b0;
      m_odd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      tick(1);
      rd(4'h4, 32'h2);
      rd(4'h8, 32'd434);
      rd(4'hC, 32'd0);
      req_i = 1'b0;
      tick(3);
      chk1("irq_after_reset", irq_o, 1'b0);
      chk1("tx_after_reset", tx_o, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic int unsigned urandom_range_w(input int unsigned lo, input int unsigned hi);
      return lo + ($urandom % (hi - lo + 1));
   endfunction
endmodule
